// File: rtl/sincronizador_vga.sv
// VGA timing generator: pixel-enable divider feeding cascaded horizontal and
// vertical counters, with hsync/vsync/videoon/frametick registered from the
// next-state counter values so every output lines up with pixelx/pixely.
module sincronizador_vga #(
  parameter int unsigned H_DISP = 640,
  parameter int unsigned H_FP   = 16,
  parameter int unsigned H_SYNC = 96,
  parameter int unsigned H_BP   = 48,
  parameter int unsigned V_DISP = 480,
  parameter int unsigned V_FP   = 10,
  parameter int unsigned V_SYNC = 2,
  parameter int unsigned V_BP   = 33,
  parameter int unsigned DIV    = 4
) (
  input  logic       clk,
  input  logic       reset,
  output logic       pixeltick,
  output logic [9:0] pixelx,
  output logic [9:0] pixely,
  output logic       videoon,
  output logic       hsync,
  output logic       vsync,
  output logic       frametick
);

  localparam int unsigned H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;
  localparam int unsigned DW      = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [9:0]    H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]    V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]    H_VIS    = 10'(H_DISP);
  localparam logic [9:0]    V_VIS    = 10'(V_DISP);
  localparam logic [9:0]    HS_BEG   = 10'(H_DISP + H_FP);
  localparam logic [9:0]    HS_END   = 10'(H_DISP + H_FP + H_SYNC);
  localparam logic [9:0]    VS_BEG   = 10'(V_DISP + V_FP);
  localparam logic [9:0]    VS_END   = 10'(V_DISP + V_FP + V_SYNC);
  localparam logic          VIDEO_AT_ORIGIN = (H_DISP > 0) && (V_DISP > 0);

  logic [DW-1:0] div;
  logic [DW-1:0] div_next;
  logic          tick_next;
  logic [9:0]    x_next;
  logic [9:0]    y_next;
  logic          video_q;

  // Next-state of divider and cascaded counters; outputs are derived from these.
  always_comb begin
    div_next  = (div == DIV_LAST) ? '0 : div + DW'(1);
    tick_next = (div_next == DIV_LAST);
    x_next    = pixelx;
    y_next    = pixely;
    if (pixeltick) begin
      if (pixelx == H_LAST) begin
        x_next = '0;
        y_next = (pixely == V_LAST) ? '0 : pixely + 10'd1;
      end else begin
        x_next = pixelx + 10'd1;
      end
    end
  end

  // Register counters and the qualifiers decoded from their next values.
  always_ff @(posedge clk) begin
    if (reset) begin
      div       <= '0;
      pixeltick <= 1'b0;
      pixelx    <= '0;
      pixely    <= '0;
      hsync     <= 1'b1;
      vsync     <= 1'b1;
      video_q   <= VIDEO_AT_ORIGIN;
      frametick <= 1'b0;
    end else begin
      div       <= div_next;
      pixeltick <= tick_next;
      pixelx    <= x_next;
      pixely    <= y_next;
      hsync     <= !((x_next >= HS_BEG) && (x_next < HS_END));
      vsync     <= !((y_next >= VS_BEG) && (y_next < VS_END));
      video_q   <= (x_next < H_VIS) && (y_next < V_VIS);
      frametick <= tick_next && (x_next == H_LAST) && (y_next == V_LAST);
    end
  end

  // The register already holds the (0,0) decode during reset; masking with
  // reset keeps videoon low while reset is held yet high on the first cycle
  // after release.
  assign videoon = video_q & ~reset;

endmodule

// File: tb/tb_sincronizador_vga.sv
// Bench for sincronizador_vga: a reduced-timing instance (DIV=4) and a
// full-line instance (DIV=2) checked every clock against an arithmetic model
// that derives all outputs from the clock count since reset release.
`timescale 1ns/1ps
module tb_sincronizador_vga;

  localparam int AHD = 16, AHF = 2, AHS = 4, AHB = 3;
  localparam int AVD = 8,  AVF = 2, AVS = 2, AVB = 3;
  localparam int ADIV = 4;
  localparam int AHT = AHD + AHF + AHS + AHB;
  localparam int AVT = AVD + AVF + AVS + AVB;
  localparam int BDIV = 2;

  typedef struct packed {
    logic       tick;
    logic [9:0] x;
    logic [9:0] y;
    logic       von;
    logic       hs;
    logic       vs;
    logic       ft;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic       tick_a, von_a, hs_a, vs_a, ft_a;
  logic [9:0] x_a, y_a;
  logic       tick_b, von_b, hs_b, vs_b, ft_b;
  logic [9:0] x_b, y_b;

  int compared = 0;
  int mismatched = 0;
  int t = 0;
  int cyc = 0;
  int last_ft = -1;
  int last_wrap = -1;
  logic [9:0] prev_xb = '0;
  exp_t ea, eb;

  always #5 clk = ~clk;

  sincronizador_vga #(
    .H_DISP(AHD), .H_FP(AHF), .H_SYNC(AHS), .H_BP(AHB),
    .V_DISP(AVD), .V_FP(AVF), .V_SYNC(AVS), .V_BP(AVB),
    .DIV(ADIV)
  ) dut_a (
    .clk(clk), .reset(reset), .pixeltick(tick_a), .pixelx(x_a), .pixely(y_a),
    .videoon(von_a), .hsync(hs_a), .vsync(vs_a), .frametick(ft_a)
  );

  sincronizador_vga #(
    .DIV(BDIV)
  ) dut_b (
    .clk(clk), .reset(reset), .pixeltick(tick_b), .pixelx(x_b), .pixely(y_b),
    .videoon(von_b), .hsync(hs_b), .vsync(vs_b), .frametick(ft_b)
  );

  // Expected outputs t clocks after the last reset edge.
  function automatic exp_t model(input int tt, input int dv,
                                 input int hd, input int hf, input int hsw, input int hb,
                                 input int vd, input int vf, input int vsw, input int vb);
    exp_t m;
    int ht = hd + hf + hsw + hb;
    int vt = vd + vf + vsw + vb;
    int n  = tt / dv;
    int x  = n % ht;
    int y  = (n / ht) % vt;
    m.tick = ((tt % dv) == dv - 1);
    m.x    = 10'(x);
    m.y    = 10'(y);
    m.von  = (x < hd) && (y < vd);
    m.hs   = !((x >= hd + hf) && (x < hd + hf + hsw));
    m.vs   = !((y >= vd + vf) && (y < vd + vf + vsw));
    m.ft   = m.tick && (x == ht - 1) && (y == vt - 1);
    return m;
  endfunction

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_all();
    cyc++;
    if (reset) begin
      t = 0;
      last_ft = -1;
      last_wrap = -1;
      prev_xb = '0;
    end else begin
      t++;
    end
    ea = model(t, ADIV, AHD, AHF, AHS, AHB, AVD, AVF, AVS, AVB);
    eb = model(t, BDIV, 640, 16, 96, 48, 480, 10, 2, 33);
    cmp("a_tick", 32'(tick_a), 32'(ea.tick));
    cmp("a_x",    32'(x_a),    32'(ea.x));
    cmp("a_y",    32'(y_a),    32'(ea.y));
    cmp("a_von",  32'(von_a),  32'(ea.von & ~reset));
    cmp("a_hs",   32'(hs_a),   32'(ea.hs));
    cmp("a_vs",   32'(vs_a),   32'(ea.vs));
    cmp("a_ft",   32'(ft_a),   32'(ea.ft));
    cmp("b_tick", 32'(tick_b), 32'(eb.tick));
    cmp("b_x",    32'(x_b),    32'(eb.x));
    cmp("b_y",    32'(y_b),    32'(eb.y));
    cmp("b_von",  32'(von_b),  32'(eb.von & ~reset));
    cmp("b_hs",   32'(hs_b),   32'(eb.hs));
    cmp("b_vs",   32'(vs_b),   32'(eb.vs));
    cmp("b_ft",   32'(ft_b),   32'(eb.ft));
    if (!reset && ft_a === 1'b1) begin
      if (last_ft >= 0) cmp("a_frame_period", 32'(cyc - last_ft), 32'(AHT * AVT * ADIV));
      last_ft = cyc;
    end
    if (!reset && x_b === 10'd0 && prev_xb === 10'd799) begin
      if (last_wrap >= 0) cmp("b_line_period", 32'(cyc - last_wrap), 32'(800 * BDIV));
      last_wrap = cyc;
    end
    if (!reset) prev_xb = x_b;
  endtask

  // One clock: check after the edge, then drive reset for the next edge.
  task automatic step(input logic r);
    logic was;
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    was = reset;
    reset = r;
    if (was && !r) begin
      #1;
      cmp("a_von_release", 32'(von_a), 32'(model(0, ADIV, AHD, AHF, AHS, AHB, AVD, AVF, AVS, AVB).von));
      cmp("b_von_release", 32'(von_b), 32'(model(0, BDIV, 640, 16, 96, 48, 480, 10, 2, 33).von));
    end
  endtask

  initial begin
    int budget;
    // Reset held for five edges, then released.
    repeat (4) step(1'b1);
    step(1'b0);
    // Two full frames of the reduced instance, several lines of the other.
    repeat (3200) step(1'b0);
    // Reset pulse while the reduced instance is inside both sync pulses.
    budget = 0;
    while (!(ea.x == 10'(AHD + AHF + 1) && ea.y == 10'(AVD + AVF)) && budget < 4000) begin
      step(1'b0);
      budget++;
    end
    cmp("a_reach_sync_region", 32'(budget < 4000), 32'd1);
    cmp("a_hs_before_reset", 32'(hs_a), 32'd0);
    cmp("a_vs_before_reset", 32'(vs_a), 32'd0);
    step(1'b1);
    step(1'b0);
    // Randomized run lengths separated by short reset pulses.
    for (int i = 0; i < 16; i++) begin
      int len = int'($urandom_range(50, 1500));
      int rl  = int'($urandom_range(1, 3));
      repeat (len) step(1'b0);
      repeat (rl - 1) step(1'b1);
      step(1'b1);
      step(1'b0);
    end
    repeat (3200) step(1'b0);
    @(posedge clk);
    #1;
    check_all();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sincronizador_vga.md
# sincronizador_vga

Generates 640x480 @ 60 Hz VGA timing from the 100 MHz system clock. It drives the pixel coordinates and the `videoon` blanking qualifier consumed by the text/letter generators, and the `hsync`/`vsync` pins of the connector. It contains a pixel-clock-enable divider and cascaded horizontal/vertical counters. All coordinate and sync outputs are registered and mutually aligned.

## Interface

Parameters:
- `H_DISP`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, horizontal sync width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_DISP`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `DIV`, 4, system clocks per pixel (≥2)

Ports:
- `clk` input 1: system clock, 100 MHz
- `reset` input 1: synchronous, active-high reset
- `pixeltick` output 1: one-`clk` pixel enable, every `DIV` clocks
- `pixelx` output 10: horizontal counter, 0..H_TOTAL-1
- `pixely` output 10: vertical counter, 0..V_TOTAL-1
- `videoon` output 1: high when (`pixelx`,`pixely`) is in the visible area
- `hsync` output 1: horizontal sync, active-low
- `vsync` output 1: vertical sync, active-low
- `frametick` output 1: one-`clk` pulse on the last pixel of a frame

Clock is one domain (`clk`); reset is synchronous and active-high.

## Operation

- `H_TOTAL` = `H_DISP+H_FP+H_SYNC+H_BP` (800); `V_TOTAL` = `V_DISP+V_FP+V_SYNC+V_BP` (525). All counters are 10-bit unsigned.
- Divider:
  - `div` counts 0..DIV-1 on every `clk` and wraps to 0.
  - `pixeltick` is registered and is high for exactly the cycle in which `div`==DIV-1.
- Horizontal counter:
  - On a `clk` edge with `pixeltick`=1, `pixelx` increments.
  - If `pixelx`==H_TOTAL-1, it wraps to 0 instead.
- Vertical counter:
  - On the same edge as a horizontal wrap, `pixely` increments.
  - If `pixely`==V_TOTAL-1, it wraps to 0 instead.
- `hsync` and `vsync` are registered from the next-state counter values, so on every cycle they correspond exactly to the current `pixelx`/`pixely`:
  - `hsync`=0 iff H_DISP+H_FP ≤ `pixelx` ≤ H_DISP+H_FP+H_SYNC-1 (656..751).
  - `vsync`=0 iff V_DISP+V_FP ≤ `pixely` ≤ V_DISP+V_FP+V_SYNC-1 (490..491).
- `videoon` = (`pixelx`<H_DISP) && (`pixely`<V_DISP), registered and aligned the same way. It is forced to 0 while `reset` is high.
- `frametick`:
  - High for one `clk` when `pixeltick`=1 and (`pixelx`,`pixely`)=(H_TOTAL-1,V_TOTAL-1).
  - That is the cycle before both counters wrap to (0,0).
- No state machine beyond the counters. Counter values outside range cannot occur.

## Timing

- Reset values: `div`=0, `pixeltick`=0, `pixelx`=0, `pixely`=0, `hsync`=1, `vsync`=1, `videoon`=0, `frametick`=0.
- After `reset` deasserts:
  - `videoon` is 1 on the first cycle, because (0,0) is visible.
  - The first `pixeltick` is high on clock cycle DIV-1, counting the first cycle after reset as 0.
  - `pixelx` becomes 1 on the cycle after that tick.
- Each coordinate is held for exactly `DIV` clocks.
  - Line period = H_TOTAL·DIV = 3200 clocks.
  - Frame period = H_TOTAL·V_TOTAL·DIV = 1,680,000 clocks.
- `hsync` low duration = H_SYNC·DIV = 384 clocks per line. `vsync` low duration = 2 full lines = 6400 clocks.
- Latency: 0 cycles between a coordinate change and the corresponding change of `hsync`/`vsync`/`videoon`. All change on the same `clk` edge.
- `reset` asserted mid-frame:
  - On the next edge, all outputs take their reset values.
  - The divider phase restarts from 0.
  - No partial sync pulse is extended.
- Simultaneous horizontal and vertical wrap at (799,524): both counters go to (0,0) on the same edge, and `vsync` is 1 there.

## Test plan

- Reset held 5 clocks, then released → all outputs at reset values during reset. `videoon`=1 from the first post-reset cycle. `pixeltick` high on cycles 3, 7, 11, ….
- Run one line → `pixelx` steps 0..799 and then wraps to 0, `pixely` 0→1 at the wrap. `hsync` falls when `pixelx`=656 and rises when `pixelx`=752, giving 384 clocks low. `videoon` falls when `pixelx`=640.
- Run one frame → `vsync` low exactly for `pixely`=490..491. `videoon`=0 for all `pixely`≥480. `frametick` pulses once, at (799,524). The next cycle shows (0,0).
- Check frame period → the interval between consecutive `frametick` pulses is exactly 1,680,000 clocks.
- Assert `reset` for 1 clock while at (700,490) with `hsync`=0 and `vsync`=0 → on the next edge, outputs are (0,0) with `hsync`=1, `vsync`=1 and `videoon`=0. Normal sequence resumes afterwards.
- Instantiate with `DIV`=2 → `pixeltick` every 2 clocks, and the line period is 1600 clocks.
